sdram_ctrl_resp_mem: RTL and testbench

//  On-chip responder for the sdram_ctrl_if controller-side bus; the same job sdram_core does, backed by a word RAM.

---
 rtl/sdram_ctrl_resp_mem.sv | 153 +++++++++++++++
 tb/tb_sdram_ctrl_resp_mem.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ctrl_resp_mem.sv
// Word-RAM responder for the sdram_ctrl_if controller-side bus.
// Models controller occupancy, fixed read latency and periodic refresh stalls.
module sdram_ctrl_resp_mem #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_WORDS      = 1024,
    parameter int READ_LATENCY   = 3,
    parameter int BUSY_CYCLES    = 2,
    parameter int REFRESH_PERIOD = 0,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] wr,
    input  logic                    rd,
    output logic                    rdy,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    protocol_err
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFS  = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int MAXC = (BUSY_CYCLES > REFRESH_CYCLES) ? BUSY_CYCLES : REFRESH_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_REFRESH} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic                    r_rdy;
    logic                    r_perr;
    logic [READ_LATENCY:0]   r_vld_pipe;
    logic [DATA_WIDTH-1:0]   r_dat_pipe [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

    logic [IW-1:0]           w_idx;
    logic                    w_wr_req;
    logic                    w_acc;
    logic                    w_acc_wr;
    logic                    w_acc_rd;
    logic                    w_ref_pend;
    logic                    w_ref_clr;
    logic                    w_unused_addr;

    // Out-of-range addresses wrap by simply dropping the upper bits.
    assign w_idx         = addr[OFS +: IW];
    assign w_unused_addr = ^addr;

    assign w_wr_req = |wr;
    assign w_acc    = r_rdy & (rd | w_wr_req);
    assign w_acc_wr = r_rdy & w_wr_req;
    assign w_acc_rd = r_rdy & rd & ~w_wr_req;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ref_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = CW'(BUSY_CYCLES - 1);
                end else if (w_ref_pend) begin
                    w_state_nxt = S_REFRESH;
                    w_cnt_nxt   = CW'(REFRESH_CYCLES - 1);
                    w_ref_clr   = 1'b1;
                end
            end
            S_BUSY, S_REFRESH: begin
                if (r_cnt == '0) w_state_nxt = S_IDLE;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // rdy is the registered image of "next state is IDLE", so it stays 0
    // for the first cycle after reset and drops on the accept edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdy   <= (w_state_nxt == S_IDLE);
            if (w_acc & rd & w_wr_req) r_perr <= 1'b1;
        end
    end

    generate
        if (REFRESH_PERIOD > 0) begin : g_ref
            localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
            logic [RW-1:0] r_ref_tmr;
            logic          r_ref_pend;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ref_tmr  <= '0;
                    r_ref_pend <= 1'b0;
                end else begin
                    if (r_ref_tmr == RW'(REFRESH_PERIOD - 1)) r_ref_tmr <= '0;
                    else                                      r_ref_tmr <= r_ref_tmr + RW'(1);
                    // A fresh wrap outranks the clear; an unserviced one just stays pending.
                    if (r_ref_tmr == RW'(REFRESH_PERIOD - 1)) r_ref_pend <= 1'b1;
                    else if (w_ref_clr)                       r_ref_pend <= 1'b0;
                end
            end
            assign w_ref_pend = r_ref_pend;
        end else begin : g_noref
            logic w_unused_ref;
            assign w_ref_pend   = 1'b0;
            assign w_unused_ref = w_ref_clr;
        end
    endgenerate

    // r_vld_pipe[0] is loaded on the accept edge; the last stage is rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_rdata    <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[READ_LATENCY-1:0], w_acc_rd};
            if (r_vld_pipe[READ_LATENCY-1]) r_rdata <= r_dat_pipe[READ_LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        r_dat_pipe[0] <= r_mem[w_idx];
        for (int i = 1; i < READ_LATENCY; i++) r_dat_pipe[i] <= r_dat_pipe[i-1];
    end

    always_ff @(posedge clk) begin
        if (w_acc_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (wr[i]) r_mem[w_idx][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
    end

    assign rdy          = r_rdy;
    assign rvalid       = r_vld_pipe[READ_LATENCY];
    assign read_data    = r_rdata;
    assign protocol_err = r_perr;

endmodule

// File: tb/tb_sdram_ctrl_resp_mem.sv
// Scoreboard bench: dut_a uses the default timing, dut_b the short-busy,
// long-latency, refresh-enabled configuration.
module tb_sdram_ctrl_resp_mem;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
    logic [3:0]  a_wr, b_wr;
    logic        a_rd, a_rdy, a_rvalid, a_perr;
    logic        b_rd, b_rdy, b_rvalid, b_perr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int a_pulses = 0;
    logic [31:0] qa[$], qb[$];
    int          qa_c[$], qb_c[$];

    sdram_ctrl_resp_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024),
        .READ_LATENCY(3), .BUSY_CYCLES(2), .REFRESH_PERIOD(0), .REFRESH_CYCLES(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .addr(a_addr), .write_data(a_wdata), .wr(a_wr),
        .rd(a_rd), .rdy(a_rdy), .rvalid(a_rvalid), .read_data(a_rdata),
        .protocol_err(a_perr)
    );

    sdram_ctrl_resp_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024),
        .READ_LATENCY(4), .BUSY_CYCLES(1), .REFRESH_PERIOD(64), .REFRESH_CYCLES(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .addr(b_addr), .write_data(b_wdata), .wr(b_wr),
        .rd(b_rd), .rdy(b_rdy), .rvalid(b_rvalid), .read_data(b_rdata),
        .protocol_err(b_perr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: pops one expectation per rvalid pulse, checks data and arrival cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        int          ec;
        if (a_rvalid) begin
            a_pulses++;
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_rvalid cyc=%0d data=%h", cyc, a_rdata);
            end else begin
                e  = qa.pop_front();
                ec = qa_c.pop_front();
                if (a_rdata !== e || cyc != ec) begin
                    errors++;
                    $display("FAIL a_read got %h at cyc %0d exp %h at cyc %0d", a_rdata, cyc, e, ec);
                end
            end
        end
        if (b_rvalid) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_rvalid cyc=%0d data=%h", cyc, b_rdata);
            end else begin
                e  = qb.pop_front();
                ec = qb_c.pop_front();
                if (b_rdata !== e || cyc != ec) begin
                    errors++;
                    $display("FAIL b_read got %h at cyc %0d exp %h at cyc %0d", b_rdata, cyc, e, ec);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic [31:0] ad, input logic [31:0] wd,
                         input logic [3:0] w, input logic r);
        if (d == 0) begin a_addr = ad; a_wdata = wd; a_wr = w; a_rd = r; end
        else        begin b_addr = ad; b_wdata = wd; b_wr = w; b_rd = r; end
    endtask

    function automatic logic rdy_of(input int d);
        return (d == 0) ? a_rdy : b_rdy;
    endfunction

    // Called at a negedge; holds the request until accepted, returns at the next negedge.
    task automatic req(input int d, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [3:0] w, input logic r, input logic push,
                       input logic [31:0] ex, output int acc);
        int n = 0;
        drive(d, ad, wd, w, r);
        while (rdy_of(d) !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL req_timeout dut=%0d addr=%h", d, ad);
            drive(d, 32'h0, 32'h0, 4'h0, 1'b0);
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (push) begin
            if (d == 0) begin qa.push_back(ex); qa_c.push_back(acc + 3); end
            else        begin qb.push_back(ex); qb_c.push_back(acc + 4); end
        end
        @(posedge clk);
        #1;
        drive(d, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk($sformatf("busy_after_accept_d%0d", d), {31'b0, rdy_of(d)}, 32'h0);
    endtask

    task automatic wait_fall(output int t);
        logic p;
        int   n;
        p = b_rdy;
        n = 0;
        t = -1;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (p && !b_rdy) begin
                t = cyc;
                break;
            end
            p = b_rdy;
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL refresh_timeout rdy never fell");
        end
    endtask

    initial begin
        int acc, p0, len, f0, f1;
        rst_n = 1'b0;
        drive(0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_rdy_a",    {31'b0, a_rdy},    32'h0);
        chk("rst_rvalid_a", {31'b0, a_rvalid}, 32'h0);
        chk("rst_rdata_a",  a_rdata,           32'h0);
        chk("rst_perr_a",   {31'b0, a_perr},   32'h0);
        chk("rst_rdy_b",    {31'b0, b_rdy},    32'h0);
        rst_n = 1'b1;
        chk("rdy_before_clk", {31'b0, a_rdy}, 32'h0);
        @(negedge clk);
        chk("rdy_first_clk_a", {31'b0, a_rdy}, 32'h1);
        chk("rdy_first_clk_b", {31'b0, b_rdy}, 32'h1);

        // Reset while a read is in flight: it must never surface.
        p0 = a_pulses;
        req(0, 32'h100, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, acc);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrd_rst_rdy",    {31'b0, a_rdy},    32'h0);
        chk("midrd_rst_rvalid", {31'b0, a_rvalid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrd_rdy_release", {31'b0, a_rdy}, 32'h1);
        repeat (6) @(negedge clk);
        chk("midrd_no_rvalid", 32'(a_pulses - p0), 32'h0);
        chk("midrd_rdata_zero", a_rdata, 32'h0);

        req(0, 32'h100, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0, acc);
        req(0, 32'h100, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCAFEF00D, acc);
        req(0, 32'h200, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0, acc);
        req(0, 32'h200, 32'hAABBCCDD, 4'b0100, 1'b0, 1'b0, 32'h0, acc);
        req(0, 32'h200, 32'h0, 4'h0, 1'b1, 1'b1, 32'h11BB3344, acc);
        req(0, 32'h1004, 32'hDEAD0001, 4'hF, 1'b0, 1'b0, 32'h0, acc);
        @(negedge clk);
        chk("busy_second_cycle_a", {31'b0, a_rdy}, 32'h0);
        @(negedge clk);
        chk("busy_end_a", {31'b0, a_rdy}, 32'h1);
        req(0, 32'h0004, 32'h0, 4'h0, 1'b1, 1'b1, 32'hDEAD0001, acc);
        req(0, 32'h103, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCAFEF00D, acc);
        repeat (8) @(negedge clk);
        chk("rdata_hold_a",  a_rdata,           32'hCAFEF00D);
        chk("rvalid_idle_a", {31'b0, a_rvalid}, 32'h0);

        // dut_b: back-to-back reads with several in flight.
        req(1, 32'h10, 32'h01010101, 4'hF, 1'b0, 1'b0, 32'h0, acc);
        req(1, 32'h14, 32'h02020202, 4'hF, 1'b0, 1'b0, 32'h0, acc);
        req(1, 32'h18, 32'h03030303, 4'hF, 1'b0, 1'b0, 32'h0, acc);
        req(1, 32'h10, 32'h0, 4'h0, 1'b1, 1'b1, 32'h01010101, acc);
        req(1, 32'h14, 32'h0, 4'h0, 1'b1, 1'b1, 32'h02020202, acc);
        req(1, 32'h18, 32'h0, 4'h0, 1'b1, 1'b1, 32'h03030303, acc);
        req(1, 32'h14, 32'h0, 4'h0, 1'b1, 1'b1, 32'h02020202, acc);

        // rd and wr together: write happens, read dropped, sticky error.
        req(1, 32'h40, 32'h5A5A5A5A, 4'hF, 1'b1, 1'b0, 32'h0, acc);
        chk("perr_set_b",   {31'b0, b_perr}, 32'h1);
        chk("perr_clear_a", {31'b0, a_perr}, 32'h0);
        req(1, 32'h40, 32'h0, 4'h0, 1'b1, 1'b1, 32'h5A5A5A5A, acc);
        repeat (6) @(negedge clk);
        chk("perr_sticky_b", {31'b0, b_perr}, 32'h1);

        // Refresh cadence while idle.
        repeat (70) @(negedge clk);
        wait_fall(f0);
        len = 0;
        while (b_rdy == 1'b0 && len < 100) begin
            len++;
            @(negedge clk);
        end
        chk("refresh_len", 32'(len), 32'd4);
        wait_fall(f1);
        chk("refresh_period", 32'(f1 - f0), 32'd64);
        // Read held through a refresh stall is taken on the first rdy=1 cycle.
        req(1, 32'h18, 32'h0, 4'h0, 1'b1, 1'b1, 32'h03030303, acc);
        chk("held_rd_accept_cyc", 32'(acc - f1), 32'd5);

        repeat (20) @(negedge clk);
        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
